ff_bank: RTL
============

# ff_bank

Parametrised bank of N single-bit storage elements, each individually configurable at run time as a D, SR, JK or T flip-flop. It is the next-generation replacement for the standalone SR flip-flop and serves as the general register-bit primitive for control and status logic. It adds per-channel enable, change-detect pulses and illegal-input detection for SR mode.

## Interface
- N, default 8: number of channels, 1..32.
- RESET_VAL, default 0 (N bits): per-channel value of q loaded on reset.
- clk input 1: single clock, rising-edge.
- reset_n input 1: asynchronous, active-low reset.
- en input N: per-channel update enable; 0 means hold.
- mode input 2N: per-channel mode, channel i in bits [2i+1:2i]. 0 = D, 1 = SR, 2 = JK, 3 = T.
- a input N: D / S / J / T input per channel.
- b input N: unused in D and T; R in SR; K in JK.
- err_clr input 1: synchronous clear of all err bits.
- q output N: stored state.
- q_bar output N: always ~q, combinational.
- chg output N: registered one-cycle pulse when q[i] changed on the previous edge.
- err output N: sticky flag for an illegal SR input (see Configuration).

## Operation
- Each channel is evaluated independently on every rising clk edge when en[i] = 1. When en[i] = 0, q[i] holds and that channel's inputs are ignored, including illegal SR detection.
- D mode: q ← a.
- SR mode: a=1, b=0 sets; a=0, b=1 clears; a=0, b=0 holds; a=1, b=1 is illegal and q holds.
- JK mode: 00 holds, 10 sets, 01 clears, 11 toggles.
- T mode: a=1 toggles; a=0 holds.
- A mode change takes effect on the same edge: the new mode is sampled together with a and b. No state besides q is mode-dependent.
- chg[i] ← (q_next[i] != q[i]). It is 0 on hold and on writing the same value.
- Reset (reset_n=0, any time including mid-operation):
  - q = RESET_VAL and q_bar = ~RESET_VAL immediately.
  - chg = 0 and err = 0.
  - Release is synchronised by the system and is not handled inside this block.

## Timing
- Latency: inputs sampled at edge k; q valid after edge k; chg pulses in the cycle after edge k, high for exactly one cycle unless a change occurs again.
- q_bar is combinational from q with no extra latency.
- Simultaneous err_clr and a new illegal SR input on the same channel: set wins, so err[i] = 1 after the edge.
- err_clr has no effect on q or chg.

## Configuration
- FF_BANK_SR_ERR_EN defined:
  - err[i] is set on any enabled edge with mode=SR, a=1, b=1.
  - err[i] stays set until err_clr or reset.
- FF_BANK_SR_ERR_EN undefined:
  - err is tied to 0 and err_clr is ignored.
  - Illegal SR input still holds q.

## Structure
- Shared package ff_pkg holds:
  - a typedef for the 2-bit mode enum: FF_D, FF_SR, FF_JK, FF_T.
  - the constant FF_MODE_W = 2.
- One sub-module, ff_cell: a single channel that computes q_next, chg_next and illegal from mode, a, b and q.
- ff_bank instantiates N ff_cell instances with a generate loop and holds the registers.

## Test plan
- Reset:
  - Stimulus: N=8, RESET_VAL=8'hA5; assert reset_n=0 mid-clock while q=8'hFF.
  - Required response: q=8'hA5 and q_bar=8'h5A immediately; chg=0 and err=0.
- D and T mix:
  - Stimulus: ch0 D with a=1; ch1 T with a=1 held for 3 edges.
  - Required response: q[0]=1 after edge 1; q[1] goes 1,0,1; chg[1] is high for 3 consecutive cycles.
- SR sequence on ch2:
  - Stimulus: (1,0), (0,1), (1,1), (0,0), one per edge.
  - Required response: q is 1,0,0,0; err[2]=1 after the third edge when the macro is defined, otherwise err[2] stays 0.
- JK on ch3 with q=0:
  - Stimulus: (1,1), (1,1), (1,0), (0,1), one per edge.
  - Required response: q is 1,0,1,0.
- Enable hold:
  - Stimulus: en[4]=0 with D a=1, and SR (1,1) on ch5 with en[5]=0.
  - Required response: q[4] and q[5] unchanged; chg=0; err[5]=0.
- err_clr collision:
  - Stimulus: err[2]=1, then err_clr=1 together with a new SR (1,1) on ch2, then err_clr=1 alone.
  - Required response: err[2] stays 1 after the collision edge, then reads 0 after the next edge.

Source files
------------

// File: rtl/ff_pkg.sv
// rtl/ff_pkg.sv - shared mode encoding for the ff_bank flip-flop channels
package ff_pkg;

  localparam int FF_MODE_W = 2;

  typedef enum logic [FF_MODE_W-1:0] {
    FF_D  = 2'd0,
    FF_SR = 2'd1,
    FF_JK = 2'd2,
    FF_T  = 2'd3
  } ff_mode_e;

endpackage

// File: rtl/ff_cell.sv
// rtl/ff_cell.sv - next-state logic for one configurable D/SR/JK/T channel
module ff_cell
  import ff_pkg::*;
(
  input  ff_mode_e mode,
  input  logic     a,
  input  logic     b,
  input  logic     q,
  output logic     q_next,
  output logic     chg_next,
  output logic     illegal
);

  always_comb begin
    q_next  = q;
    illegal = 1'b0;
    case (mode)
      FF_D:  q_next = a;
      FF_SR: begin
        // S=R=1 is flagged but leaves q untouched
        if (a && b)   illegal = 1'b1;
        else if (a)   q_next  = 1'b1;
        else if (b)   q_next  = 1'b0;
      end
      FF_JK: begin
        case ({a, b})
          2'b10:   q_next = 1'b1;
          2'b01:   q_next = 1'b0;
          2'b11:   q_next = ~q;
          default: q_next = q;
        endcase
      end
      FF_T:    q_next = a ? ~q : q;
      default: q_next = q;
    endcase
  end

  assign chg_next = q_next ^ q;

endmodule

// File: rtl/ff_bank.sv
// rtl/ff_bank.sv - N-channel run-time configurable flip-flop bank; FF_BANK_SR_ERR_EN enables sticky SR error flags
module ff_bank
  import ff_pkg::*;
#(
  parameter int            N         = 8,
  parameter logic [N-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N-1:0]     en,
  input  logic [2*N-1:0]   mode,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic             err_clr,
  output logic [N-1:0]     q,
  output logic [N-1:0]     q_bar,
  output logic [N-1:0]     chg,
  output logic [N-1:0]     err
);

  logic [N-1:0] q_q, q_d;
  logic [N-1:0] chg_q, chg_d;
  logic [N-1:0] q_nxt, chg_nxt, illegal;

  for (genvar i = 0; i < N; i++) begin : g_cell
    ff_cell u_cell (
      .mode     (ff_mode_e'(mode[FF_MODE_W*i +: FF_MODE_W])),
      .a        (a[i]),
      .b        (b[i]),
      .q        (q_q[i]),
      .q_next   (q_nxt[i]),
      .chg_next (chg_nxt[i]),
      .illegal  (illegal[i])
    );
  end

  // Disabled channels hold and never report a change
  assign q_d   = (en & q_nxt) | (~en & q_q);
  assign chg_d = en & chg_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q   <= RESET_VAL;
      chg_q <= '0;
    end else begin
      q_q   <= q_d;
      chg_q <= chg_d;
    end
  end

`ifdef FF_BANK_SR_ERR_EN
  logic [N-1:0] err_q, err_d;

  // A new illegal input on the clear edge wins over err_clr
  assign err_d = (err_clr ? '0 : err_q) | (en & illegal);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_q <= '0;
    else          err_q <= err_d;
  end

  assign err = err_q;
`else
  logic unused_err_in;
  assign unused_err_in = err_clr ^ (|illegal);
  assign err = '0;
`endif

  assign q     = q_q;
  assign q_bar = ~q_q;
  assign chg   = chg_q;

endmodule
